// File: rtl/fp_pkg.sv
// Shared FPU definitions: FSM state codes, operand classes,
// exponent bias and canonical quiet-NaN helpers.
package fp_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBN,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_cls_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, 0...} right-aligned in 128 bits.
  function automatic logic [127:0] canonical_qnan(
    input int exp_w,
    input int man_w
  );
    logic [127:0] v;
    v = ((128'd1 << exp_w) - 128'd1) << man_w;
    v = v | (128'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: a -> class code, sign,
// significand with hidden bit (0 for zero/subnormal exponent).
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a,
  output fp_cls_e              cls,
  output logic                 neg,
  output logic [MAN_W:0]       sig
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  always_comb begin
    exp_f     = a[EXP_W+MAN_W-1:MAN_W];
    frac      = a[MAN_W-1:0];
    exp_zero  = (exp_f == '0);
    exp_ones  = &exp_f;
    frac_zero = (frac == '0);
    neg       = a[EXP_W+MAN_W];
    sig       = {~exp_zero, frac};
    cls       = CLS_NORM;
    unique case (1'b1)
      exp_zero && frac_zero:  cls = CLS_ZERO;
      exp_zero && !frac_zero: cls = CLS_SUBN;
      exp_ones && frac_zero:  cls = CLS_INF;
      exp_ones && !frac_zero
        && frac[MAN_W-1]:     cls = CLS_QNAN;
      exp_ones && !frac_zero
        && !frac[MAN_W-1]:    cls = CLS_SNAN;
      default:                cls = CLS_NORM;
    endcase
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Sequential IEEE-754 sqrt, restoring radix-2, RNE, one bit/clk.
// in_valid/in_ready/a -> out_valid/out_ready/result + flags.
module fp_sqrt_iter
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int XLEN  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            invalid,
  output logic            inexact,
  output logic            denorm
);

  localparam int RTW = MAN_W + 2;
  localparam int RW  = 2 * RTW;
  localparam int TW  = RTW + 4;
  localparam int CW  = $clog2(RTW + 1);

  localparam logic [CW-1:0]    LAST = CW'(RTW - 1);
  localparam logic [EXP_W-1:0] HBIAS =
    EXP_W'(bias(EXP_W) >> 1);
  localparam logic [127:0]     QNAN_ALL =
    canonical_qnan(EXP_W, MAN_W);
  localparam logic [XLEN-1:0]  QNAN = QNAN_ALL[XLEN-1:0];

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rad_q, rad_d;
  logic [TW-1:0]    rem_q, rem_d;
  logic [RTW-1:0]   root_q, root_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             invalid_q, invalid_d;
  logic             inexact_q, inexact_d;
  logic             denorm_q, denorm_d;

  fp_cls_e        cls;
  logic           neg;
  logic [MAN_W:0] sig;

  fp_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cls (
    .a   (a),
    .cls (cls),
    .neg (neg),
    .sig (sig)
  );

  logic             idle;
  logic [EXP_W-1:0] e_f;
  logic             odd;
  logic [RTW-1:0]   m;
  logic [RW-1:0]    rad_init;
  logic [EXP_W-1:0] exp_calc;

  // Even biased exponent means odd unbiased one, so the
  // significand takes one extra left shift to make it even.
  // (E + bias - odd) / 2 == E[W-1:1] + bias/2 + E[0] because
  // bias is odd; this form never needs the spare bit.
  always_comb begin
    idle     = (state_q == S_IDLE);
    e_f      = a[XLEN-2:MAN_W];
    odd      = ~e_f[0];
    m        = odd ? {sig, 1'b0} : {1'b0, sig};
    rad_init = {m, {RTW{1'b0}}};
    exp_calc = {1'b0, e_f[EXP_W-1:1]} + HBIAS
             + {{(EXP_W-1){1'b0}}, e_f[0]};
  end

  logic [RW-1:0]  rad_src;
  logic [TW-3:0]  rem_lo;
  logic [RTW-1:0] root_src;
  logic [TW-1:0]  cat;
  logic [TW-1:0]  trial;
  logic           take;
  logic [TW-1:0]  step_rem;
  logic [RTW-1:0] step_root;
  logic [RW-1:0]  step_rad;

  // The accept edge runs the first iteration from a zero
  // remainder, so CALC only needs RTW-1 more edges.
  always_comb begin
    rad_src   = idle ? rad_init : rad_q;
    rem_lo    = idle ? '0 : rem_q[TW-3:0];
    root_src  = idle ? '0 : root_q;
    cat       = {rem_lo, rad_src[RW-1:RW-2]};
    trial     = cat - {2'b00, root_src, 2'b01};
    take      = ~trial[TW-1];
    step_rem  = take ? trial : cat;
    step_root = {root_src[RTW-2:0], take};
    step_rad  = {rad_src[RW-3:0], 2'b00};
  end

  logic             guard;
  logic             sticky;
  logic             inc;
  logic [MAN_W:0]   frac_sum;
  logic [EXP_W-1:0] exp_rnd;
  logic [XLEN-1:0]  rnd_res;

  always_comb begin
    guard    = root_q[0];
    sticky   = |rem_q;
    inc      = guard & (sticky | root_q[1]);
    frac_sum = {1'b0, root_q[RTW-2:1]}
             + {{MAN_W{1'b0}}, inc};
    exp_rnd  = exp_q
             + {{(EXP_W-1){1'b0}}, frac_sum[MAN_W]};
    rnd_res  = {1'b0, exp_rnd, frac_sum[MAN_W-1:0]};
  end

  logic            sp;
  logic [XLEN-1:0] sp_res;
  logic            sp_inv;
  logic            sp_den;

  always_comb begin
    sp     = 1'b1;
    sp_res = QNAN;
    sp_inv = 1'b0;
    sp_den = 1'b0;
    unique case (cls)
      CLS_ZERO: sp_res = a;
      CLS_SUBN: begin
        sp_res = {a[XLEN-1], {(XLEN-1){1'b0}}};
        sp_den = 1'b1;
      end
      CLS_QNAN: sp_res = QNAN;
      CLS_SNAN: sp_inv = 1'b1;
      CLS_INF: begin
        if (neg) sp_inv = 1'b1;
        else     sp_res = a;
      end
      default: begin
        if (neg) sp_inv = 1'b1;
        else     sp = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    exp_d     = exp_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    denorm_d  = denorm_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          invalid_d = 1'b0;
          inexact_d = 1'b0;
          denorm_d  = 1'b0;
          if (sp) begin
            result_d  = sp_res;
            invalid_d = sp_inv;
            denorm_d  = sp_den;
            state_d   = S_DONE;
          end else begin
            rad_d   = step_rad;
            rem_d   = step_rem;
            root_d  = step_root;
            cnt_d   = CW'(1);
            exp_d   = exp_calc;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rad_d  = step_rad;
        rem_d  = step_rem;
        root_d = step_root;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d  = rnd_res;
        inexact_d = guard | sticky;
        state_d   = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      exp_q     <= '0;
      result_q  <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
      denorm_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
      denorm_q  <= denorm_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;
  assign denorm    = denorm_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: single (8/23) and half
// (5/10) instances, directed vectors, latency/backpressure/reset.
module tb_fp_sqrt_iter;

  typedef struct {
    logic [31:0] res;
    bit          inv;
    bit          inex;
    bit          den;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] a0, result0;
  logic        invalid0, inexact0, denorm0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0] a1, result1;
  logic        invalid1, inexact1, denorm1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   acc0   = 0;
  int   acc1   = 0;
  bit   prev0  = 0;
  bit   prev1  = 0;

  fp_sqrt_iter u_sp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a         (a0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .result    (result0),
    .invalid   (invalid0),
    .inexact   (inexact0),
    .denorm    (denorm0)
  );

  fp_sqrt_iter #(
    .EXP_W (5),
    .MAN_W (10)
  ) u_hp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .result    (result1),
    .invalid   (invalid1),
    .inexact   (inexact1),
    .denorm    (denorm1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  // Single-precision monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (in_valid0 && in_ready0 && !rst) acc0 = cyc;
      if (out_valid0 && !prev0 && q0.size() > 0)
        chk("lat0", cyc - acc0, q0[0].lat);
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          n_chk++;
          $display("FAIL out0 unexpected got=%h", result0);
        end else begin
          e = q0.pop_front();
          chk("res0", result0, e.res);
          chk("inv0", invalid0, e.inv);
          chk("inex0", inexact0, e.inex);
          chk("den0", denorm0, e.den);
        end
      end
      prev0 = out_valid0;
    end
  end

  // Half-precision monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (in_valid1 && in_ready1 && !rst) acc1 = cyc;
      if (out_valid1 && !prev1 && q1.size() > 0)
        chk("lat1", cyc - acc1, q1[0].lat);
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          n_chk++;
          $display("FAIL out1 unexpected got=%h", result1);
        end else begin
          e = q1.pop_front();
          chk("res1", result1, e.res);
          chk("inv1", invalid1, e.inv);
          chk("inex1", inexact1, e.inex);
          chk("den1", denorm1, e.den);
        end
      end
      prev1 = out_valid1;
    end
  end

  task automatic op(input bit s, input logic [31:0] av,
                    input logic [31:0] er, input bit ei,
                    input bit ex, input bit ed,
                    input int el, input int hold);
    exp_t e;
    int   n;
    e = '{er, ei, ex, ed, el};
    if (s) q1.push_back(e);
    else   q0.push_back(e);
    @(negedge clk);
    if (s) begin
      a1 = av[15:0];
      in_valid1 = 1'b1;
    end else begin
      a0 = av;
      in_valid0 = 1'b1;
      out_ready0 = (hold == 0);
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    if (!s && hold > 0) begin
      n = 0;
      while (!out_valid0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < hold; i++) begin
        chk("bp_valid", out_valid0, 1'b1);
        chk("bp_res", result0, er);
        chk("bp_inex", inexact0, ex);
        chk("bp_rdy", in_ready0, 1'b0);
        @(negedge clk);
      end
      out_ready0 = 1'b1;
      @(negedge clk);
      chk("bp_idle", in_ready0, 1'b1);
      chk("bp_drop", out_valid0, 1'b0);
    end
    n = 0;
    while (!(s ? in_ready1 : in_ready0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle", s ? in_ready1 : in_ready0, 1'b1);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    a0 = '0;
    a1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy0", in_ready0, 1'b1);
    chk("rst_vld0", out_valid0, 1'b0);
    chk("rst_res0", result0, 32'h0);
    chk("rst_flags0", {invalid0, inexact0, denorm0}, 3'b000);
    chk("rst_rdy1", in_ready1, 1'b1);
    chk("rst_res1", result1, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    op(0, 32'h40800000, 32'h40000000, 0, 0, 0, 26, 0);
    op(0, 32'h40000000, 32'h3FB504F3, 0, 1, 0, 26, 0);
    op(0, 32'h3E800000, 32'h3F000000, 0, 0, 0, 26, 0);
    op(0, 32'h40400000, 32'h3FDDB3D7, 0, 1, 0, 26, 0);
    op(0, 32'hBF800000, 32'h7FC00000, 1, 0, 0, 1, 0);
    op(0, 32'h7F800000, 32'h7F800000, 0, 0, 0, 1, 0);
    op(0, 32'h80000000, 32'h80000000, 0, 0, 0, 1, 0);
    op(0, 32'h00000000, 32'h00000000, 0, 0, 0, 1, 0);
    op(0, 32'h00000001, 32'h00000000, 0, 0, 1, 1, 0);
    op(0, 32'h80400000, 32'h80000000, 0, 0, 1, 1, 0);
    op(0, 32'h7F800001, 32'h7FC00000, 1, 0, 0, 1, 0);
    op(0, 32'h7FC00000, 32'h7FC00000, 0, 0, 0, 1, 0);
    op(0, 32'hFF800000, 32'h7FC00000, 1, 0, 0, 1, 0);
    op(0, 32'h40000000, 32'h3FB504F3, 0, 1, 0, 26, 5);

    // Offers during CALC must be ignored.
    e = '{32'h3F000000, 0, 0, 0, 26};
    q0.push_back(e);
    @(negedge clk);
    a0 = 32'h3E800000;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    a0 = 32'h7F800000;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (2) @(negedge clk);
    a0 = 32'hBF800000;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n = 0;
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_idle", in_ready0, 1'b1);

    // Reset in the middle of CALC abandons the op.
    e = '{32'h3FB504F3, 0, 1, 0, 26};
    q0.push_back(e);
    @(negedge clk);
    a0 = 32'h40000000;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(q0.pop_back());
    #1;
    chk("mid_rdy", in_ready0, 1'b1);
    chk("mid_vld", out_valid0, 1'b0);
    chk("mid_res", result0, 32'h0);
    chk("mid_flags", {invalid0, inexact0, denorm0}, 3'b000);
    op(0, 32'h41100000, 32'h40400000, 0, 0, 0, 26, 0);

    op(1, 32'h4400, 32'h4000, 0, 0, 0, 13, 0);
    op(1, 32'h4000, 32'h3DA8, 0, 1, 0, 13, 0);
    op(1, 32'h4200, 32'h3EEE, 0, 1, 0, 13, 0);
    op(1, 32'hBC00, 32'h7E00, 1, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
